// File: rtl/cache_ctrl_fsm_if.sv
// Bundles the CPU, cache-array and main-memory handshakes of the cache
// sequencing controller.
//   slave  : controller view (cache_ctrl_fsm)
//   master : environment view (CPU, cache array, memory)
// Signals:
//   cpu_req/cpu_addr/cpu_ready/cpu_valid/cpu_data    CPU read channel
//   cache_addr/cache_hit/cache_rdata                 array lookup
//   cache_fill_en/cache_fill_data                    array line write
//   mem_req/mem_addr/mem_ack/mem_rvalid/mem_rdata    memory line fetch
//   hit_count/miss_count                             saturating perf counters
interface cache_ctrl_fsm_if;
  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned LINE_ADDR_W = 13;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LINE_W      = 4 * WORD_W;
  localparam int unsigned CNT_W       = 14;

  logic                   cpu_req;
  logic [ADDR_W-1:0]      cpu_addr;
  logic                   cpu_ready;
  logic                   cpu_valid;
  logic [WORD_W-1:0]      cpu_data;
  logic [ADDR_W-1:0]      cache_addr;
  logic                   cache_hit;
  logic [WORD_W-1:0]      cache_rdata;
  logic                   cache_fill_en;
  logic [LINE_W-1:0]      cache_fill_data;
  logic                   mem_req;
  logic [LINE_ADDR_W-1:0] mem_addr;
  logic                   mem_ack;
  logic                   mem_rvalid;
  logic [WORD_W-1:0]      mem_rdata;
  logic [CNT_W-1:0]       hit_count;
  logic [CNT_W-1:0]       miss_count;

  modport slave (
    input  cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rvalid, mem_rdata,
    output cpu_ready, cpu_valid, cpu_data, cache_addr, cache_fill_en, cache_fill_data,
           mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rvalid, mem_rdata,
    input  cpu_ready, cpu_valid, cpu_data, cache_addr, cache_fill_en, cache_fill_data,
           mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a direct-mapped cache with 4-word lines.
// One CPU read in flight: 1-cycle tag lookup, hits returned directly; misses
// fetch the line word-serially from memory, write it to the array in one fill
// cycle and then return the requested word. Saturating hit/miss counters.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  cache_ctrl_fsm_if.slave (CPU, array and memory handshakes, counters)
module cache_ctrl_fsm (
  input logic             clk,
  input logic             rst,
  cache_ctrl_fsm_if.slave bus
);
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CNT_W      = 14;
  localparam int unsigned LINE_WORDS = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, FILL, WRITE, RESP} stateT;

  stateT                             state, stateNext;
  logic [ADDR_W-1:0]                 addrReg, addrNext;
  logic [OFFSET_W-1:0]               beat, beatNext;
  logic [LINE_WORDS-1:0][WORD_W-1:0] line, lineNext;
  logic [CNT_W-1:0]                  hitCnt, hitNext, missCnt, missNext;
  logic [WORD_W-1:0]                 dataNext;
  logic                              readyNext, validNext, fillEnNext, memReqNext;

  // State and registered outputs; reset drops mem_req and discards any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      addrReg           <= '0;
      beat              <= '0;
      line              <= '0;
      hitCnt            <= '0;
      missCnt           <= '0;
      bus.cpu_ready     <= 1'b1;
      bus.cpu_valid     <= 1'b0;
      bus.cpu_data      <= '0;
      bus.cache_fill_en <= 1'b0;
      bus.mem_req       <= 1'b0;
    end else begin
      state             <= stateNext;
      addrReg           <= addrNext;
      beat              <= beatNext;
      line              <= lineNext;
      hitCnt            <= hitNext;
      missCnt           <= missNext;
      bus.cpu_ready     <= readyNext;
      bus.cpu_valid     <= validNext;
      bus.cpu_data      <= dataNext;
      bus.cache_fill_en <= fillEnNext;
      bus.mem_req       <= memReqNext;
    end
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    stateNext = state;
    addrNext  = addrReg;
    beatNext  = beat;
    lineNext  = line;
    hitNext   = hitCnt;
    missNext  = missCnt;
    dataNext  = '0;

    unique case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          addrNext  = bus.cpu_addr;
          stateNext = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.cache_hit) begin
          dataNext  = bus.cache_rdata;
          hitNext   = (hitCnt == CNT_MAX) ? hitCnt : hitCnt + CNT_W'(1);
          stateNext = RESP;
        end else begin
          missNext  = (missCnt == CNT_MAX) ? missCnt : missCnt + CNT_W'(1);
          stateNext = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (bus.mem_ack) begin
          beatNext  = '0;
          stateNext = FILL;
        end
      end
      FILL: begin
        // Beats arrive in offset order; gaps just hold the beat counter.
        if (bus.mem_rvalid) begin
          lineNext[beat] = bus.mem_rdata;
          beatNext       = beat + OFFSET_W'(1);
          if (beat == OFFSET_W'(LINE_WORDS - 1)) stateNext = WRITE;
        end
      end
      WRITE: begin
        dataNext  = line[addrReg[OFFSET_W-1:0]];
        stateNext = RESP;
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Strobes are registered, so they are keyed off the state being entered.
    readyNext  = (stateNext == IDLE);
    validNext  = (stateNext == RESP);
    fillEnNext = (stateNext == WRITE);
    memReqNext = (stateNext == MEM_REQ);
  end

  // In IDLE the array sees the incoming address so the lookup can start at accept.
  assign bus.cache_addr      = (state == IDLE) ? bus.cpu_addr : addrReg;
  assign bus.cache_fill_data = line;
  assign bus.mem_addr        = addrReg[ADDR_W-1:OFFSET_W];
  assign bus.hit_count       = hitCnt;
  assign bus.miss_count      = missCnt;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Self-checking bench for cache_ctrl_fsm: directed scenarios plus random reads,
// checked against a reference of resident lines, a memory content function and
// saturating counters. The bench also plays the cache array and main memory.
module tb_cache_ctrl_fsm;
  localparam int unsigned CNT_W = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  logic         forceHit;
  logic [31:0]  forceData;
  logic [2:0]   envTag   [1024];
  logic         envValid [1024] = '{default: 1'b0};
  logic [127:0] envData  [1024];
  logic [2:0]   refTag   [1024];
  logic         refValid [1024] = '{default: 1'b0};
  logic [CNT_W-1:0] hitM, missM;
  int           pulses;

  cache_ctrl_fsm_if bus();

  cache_ctrl_fsm dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Cache array: combinational lookup, line written on the fill strobe.
  always_comb begin
    if (forceHit) begin
      bus.cache_hit   = 1'b1;
      bus.cache_rdata = forceData;
    end else begin
      bus.cache_hit   = envValid[bus.cache_addr[11:2]] &&
                        (envTag[bus.cache_addr[11:2]] == bus.cache_addr[14:12]);
      bus.cache_rdata = envData[bus.cache_addr[11:2]][{bus.cache_addr[1:0], 5'b0} +: 32];
    end
  end

  always @(posedge clk) begin
    if (bus.cache_fill_en) begin
      envValid[bus.cache_addr[11:2]] <= 1'b1;
      envTag[bus.cache_addr[11:2]]   <= bus.cache_addr[14:12];
      envData[bus.cache_addr[11:2]]  <= bus.cache_fill_data;
    end
  end

  // Main-memory contents; line 1 holds A0..A3.
  function automatic logic [31:0] memWord(input logic [12:0] ln, input logic [1:0] o);
    if (ln == 13'h0001) return 32'hA0 + 32'(o);
    return {ln, 17'h0A5C, o};
  endfunction

  function automatic logic [127:0] memLine(input logic [12:0] ln);
    return {memWord(ln, 2'd3), memWord(ln, 2'd2), memWord(ln, 2'd1), memWord(ln, 2'd0)};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic resetDut();
    rst            = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = 15'h1abc;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    hitM  = '0;
    missM = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rstReady", bus.cpu_ready, 1'b1);
    chk("rstValid", bus.cpu_valid, 1'b0);
    chk("rstData", bus.cpu_data, 32'h0);
    chk("rstFillEn", bus.cache_fill_en, 1'b0);
    chk("rstFillData", bus.cache_fill_data, 128'h0);
    chk("rstMemReq", bus.mem_req, 1'b0);
    chk("rstMemAddr", bus.mem_addr, 13'h0);
    chk("rstHits", bus.hit_count, 14'h0);
    chk("rstMisses", bus.miss_count, 14'h0);
    chk("rstCacheAddr", bus.cache_addr, bus.cpu_addr);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One CPU read from the idle state; plays memory and checks every cycle.
  // pat/patLen: explicit mem_rvalid sequence (LSB first), then random gaps.
  // holdReq: keep cpu_req high with wandering cpu_addr. abortAfter: reset after N beats.
  task automatic doRead(input logic [14:0] a, input int ackWait, input logic [7:0] pat,
                        input int patLen, input int gapPct, input bit holdReq,
                        input int abortAfter);
    logic [9:0]  idx;
    logic [2:0]  tg;
    logic [12:0] ln;
    logic [31:0] expData;
    bit          expHit, done, expReq;
    int          ackAt, beatsSent, lastBeatK, expValidK, fills, patPos;
    idx = a[11:2];
    tg  = a[14:12];
    ln  = a[14:2];
    expHit    = forceHit || (refValid[idx] && refTag[idx] == tg);
    expData   = forceHit ? forceData : memWord(ln, a[1:0]);
    ackAt     = -1;
    beatsSent = 0;
    lastBeatK = -1;
    expValidK = expHit ? 1 : -1;
    fills     = 0;
    patPos    = 0;
    done      = 1'b0;

    chk("idleReady", bus.cpu_ready, 1'b1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    #1 chk("idleCacheAddr", bus.cache_addr, a);
    if (expHit) hitM = (hitM == CNT_MAX) ? hitM : hitM + CNT_W'(1);
    else        missM = (missM == CNT_MAX) ? missM : missM + CNT_W'(1);

    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (holdReq) bus.cpu_addr = 15'($urandom);
      else         bus.cpu_req  = 1'b0;

      expReq = !expHit && k >= 1 && ackAt < 0;
      chk("busyReady", bus.cpu_ready, 1'b0);
      chk("latchedAddr", bus.cache_addr, a);
      chk("validPulse", bus.cpu_valid, k == expValidK);
      chk("readData", bus.cpu_data, (k == expValidK) ? expData : 32'h0);
      chk("memReq", bus.mem_req, expReq);
      if (expReq) chk("memAddr", bus.mem_addr, ln);
      chk("fillEn", bus.cache_fill_en, lastBeatK >= 0 && k == lastBeatK + 1);
      if (bus.cache_fill_en) begin
        fills++;
        chk("fillData", bus.cache_fill_data, memLine(ln));
      end
      if (k == expValidK) done = 1'b1;

      if (!expHit && ackAt < 0 && k >= 1) begin
        if (k - 1 == ackWait) begin
          bus.mem_ack = 1'b1;
          ackAt = k;
        end else begin
          bus.mem_rvalid = 1'($urandom);
        end
      end else if (ackAt >= 0 && beatsSent < 4) begin
        if (beatsSent == abortAfter) begin
          rst = 1'b1;
          bus.cpu_req = 1'b0;
          #1;
          chk("abortMemReq", bus.mem_req, 1'b0);
          chk("abortReady", bus.cpu_ready, 1'b1);
          chk("abortFillEn", bus.cache_fill_en, 1'b0);
          chk("abortHits", bus.hit_count, 14'h0);
          chk("abortMisses", bus.miss_count, 14'h0);
          hitM  = '0;
          missM = '0;
          @(negedge clk);
          rst = 1'b0;
          for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("abortNoFill", bus.cache_fill_en, 1'b0);
            chk("abortIdle", bus.cpu_ready, 1'b1);
            chk("abortNoReq", bus.mem_req, 1'b0);
          end
          return;
        end
        bus.mem_ack = 1'($urandom);
        if (patPos < patLen) begin
          bus.mem_rvalid = pat[patPos];
          patPos++;
        end else begin
          bus.mem_rvalid = ($urandom_range(0, 99) >= 32'(gapPct));
        end
        if (bus.mem_rvalid) begin
          bus.mem_rdata = memWord(ln, 2'(beatsSent));
          beatsSent++;
          if (beatsSent == 4) begin
            lastBeatK = k;
            expValidK = k + 2;
          end
        end
      end else begin
        bus.mem_rvalid = 1'($urandom);
      end
    end
    chk("noTimeout", done, 1'b1);

    @(negedge clk);
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("backIdle", bus.cpu_ready, 1'b1);
    chk("validOnce", bus.cpu_valid, 1'b0);
    chk("dataZero", bus.cpu_data, 32'h0);
    chk("hitCount", bus.hit_count, hitM);
    chk("missCount", bus.miss_count, missM);
    chk("fillCount", fills, expHit ? 0 : 1);
    if (!expHit && !forceHit) begin
      refValid[idx] = 1'b1;
      refTag[idx]   = tg;
    end
  endtask

  initial begin
    forceHit  = 1'b0;
    forceData = '0;
    resetDut();

    // Cold miss on line 1, then a hit on the same word.
    doRead(15'h0005, 2, 8'h00, 0, 0, 1'b0, -1);
    doRead(15'h0005, 0, 8'h00, 0, 0, 1'b0, -1);

    // Gapped beats 1,0,1,0,1,1.
    doRead(15'h4C8A, 0, 8'b0011_0101, 6, 0, 1'b0, -1);

    // Request held through a miss, then the next one right after the response.
    doRead(15'h2043, 1, 8'h00, 0, 0, 1'b1, -1);
    doRead(15'h0005, 0, 8'h00, 0, 0, 1'b0, -1);

    // Random reads over a small address pool so lines are reused and evicted.
    for (int r = 0; r < 80; r++) begin
      logic [14:0] ra;
      ra = {3'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 2'($urandom)};
      doRead(ra, $urandom_range(0, 3), 8'h00, 0, 30, 1'($urandom_range(0, 1)), -1);
    end

    // Reset during the fill after two beats; the line must still be absent.
    doRead(15'h7014, 0, 8'h00, 0, 0, 1'b0, 2);
    doRead(15'h7016, 1, 8'h00, 0, 20, 1'b0, -1);

    // Saturate the hit counter.
    resetDut();
    forceHit  = 1'b1;
    forceData = 32'hC0FFEE11;
    pulses    = 0;
    bus.cpu_req = 1'b1;
    for (int c = 0; c < 60000 && pulses < 16383; c++) begin
      @(negedge clk);
      bus.cpu_addr = 15'($urandom);
      if (bus.cpu_valid) begin
        pulses++;
        if (pulses == 16383) bus.cpu_req = 1'b0;
      end
    end
    @(negedge clk);
    hitM = (pulses >= int'(CNT_MAX)) ? CNT_MAX : CNT_W'(pulses);
    chk("bulkPulses", pulses, 16383);
    chk("satHits", bus.hit_count, hitM);
    chk("satMisses", bus.miss_count, missM);
    doRead(15'h3333, 0, 8'h00, 0, 0, 1'b0, -1);
    chk("satStays", bus.hit_count, 14'h3FFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
